// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC multiplier datapath.
// Holds the multiplier FSM encoding and the default operand width.
package mac_pkg;

  localparam int MAC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mac_state_e;

endpackage

// File: rtl/mac_sign_conv.sv
// Two's complement magnitude/sign split and final conditional negate.
// Used by mac_seq_multiplier only when MAC_MUL_SIGNED_EN is defined.
module mac_sign_conv #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH:0]     mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               sign,
  input  logic [2*WIDTH-1:0] raw,
  input  logic               neg,
  output logic [2*WIDTH-1:0] res
);

  logic [WIDTH:0] ext_a;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1)
  always_comb begin
    ext_a = {a[WIDTH-1], a};
    mag_a = a[WIDTH-1] ? (~ext_a + 1'b1) : ext_a;
    mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    sign  = a[WIDTH-1] ^ b[WIDTH-1];
  end

  // Restore the sign of the unsigned core result
  always_comb begin
    res = neg ? (~raw + 1'b1) : raw;
  end

endmodule

// File: rtl/mac_seq_multiplier.sv
// Radix-2 shift-add multiplier, one partial product per clock.
// Define MAC_MUL_SIGNED_EN for two's complement operands.
module mac_seq_multiplier
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_mul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               valid_mul,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef MAC_MUL_SIGNED_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  mac_state_e state, state_nx;

  logic             start_q;
  logic [MW-1:0]    mcand;
  logic [MW-1:0]    acc_hi;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] count;

  logic               accept;
  logic [MW-1:0]      addend;
  logic [MW:0]        sum;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] fin;
  logic [MW-1:0]      cap_a;
  logic [WIDTH-1:0]   cap_b;

`ifdef MAC_MUL_SIGNED_EN
  logic sign_c;
  logic sign_q;

  mac_sign_conv #(
    .WIDTH (WIDTH)
  ) u_sign (
    .a     (a),
    .b     (b),
    .mag_a (cap_a),
    .mag_b (cap_b),
    .sign  (sign_c),
    .raw   (raw),
    .neg   (sign_q),
    .res   (fin)
  );

  // Result sign is latched with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
    end else if (accept) begin
      sign_q <= sign_c;
    end
  end
`else
  assign cap_a = a;
  assign cap_b = b;
  assign fin   = raw;
`endif

  assign accept    = start_mul & ~start_q & (state == IDLE);
  assign busy      = (state == RUN);
  assign valid_mul = (state == DONE);

  // One shift-add step; the sum keeps its carry bit
  always_comb begin
    addend = mplr[0] ? mcand : '0;
    sum    = {1'b0, acc_hi} + {1'b0, addend};
    raw    = {sum[WIDTH:0], mplr[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE: if (accept) state_nx = RUN;
      state == RUN:  if (count == LAST) state_nx = DONE;
      default:       state_nx = IDLE;
    endcase
  end

  // Operand capture, shift-add datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      mcand   <= '0;
      acc_hi  <= '0;
      mplr    <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      start_q <= start_mul;
      if (accept) begin
        mcand  <= cap_a;
        mplr   <= cap_b;
        acc_hi <= '0;
        count  <= '0;
      end else if (state == RUN) begin
        acc_hi <= sum[MW:1];
        mplr   <= {sum[0], mplr[WIDTH-1:1]};
        count  <= count + 1'b1;
        if (count == LAST) begin
          product <= fin;
        end
      end
    end
  end

endmodule
